cacheline_adaptor: RTL and testbench

CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

---
 rtl/cacheline_adaptor.sv | 146 ++++++++++++++
 tb/tb_cacheline_adaptor.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor
//   Bridges a cache datapath that moves whole lines (s_line bits) to a memory
//   port that moves fixed-size beats (s_burst bits, four beats per line).
//   A line read is assembled beat by beat into line_o. A line write is
//   latched and then streamed out on burst_o. resp_o pulses for one cycle
//   once all four beats have been exchanged.
//
// Ports
//   clk        single clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   line_i     writeback line from the cache datapath
//   line_o     assembled fill line to the cache datapath
//   address_i  line address from the cache datapath
//   read_i     line-read request (level, held until resp_o)
//   write_i    line-write request (level, held until resp_o)
//   resp_o     one-cycle completion pulse to the cache controller
//   burst_i    read beat from memory
//   burst_o    write beat to memory
//   address_o  latched burst address to memory
//   read_o     memory burst-read request
//   write_o    memory burst-write request
//   resp_i     memory beat strobe, one beat per high cycle
//
// Configuration
//   CACHELINE_ADAPTOR_ADDR_ALIGN_EN  when defined, address_o[4:0] is forced
//                                    to zero (32-byte line alignment).

module cacheline_adaptor #(
  parameter int s_line  = 256,
  parameter int s_burst = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [s_line-1:0]  line_i,
  output logic [s_line-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [s_burst-1:0] burst_i,
  output logic [s_burst-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int         beats     = s_line / s_burst;
  localparam logic [1:0] last_beat = 2'(beats - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [1:0]        count;
  logic [s_line-1:0] line_buf;
  logic [31:0]       addr_q;

  // State register plus the datapath registers it controls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= 2'd0;
      line_o   <= '0;
      line_buf <= '0;
      addr_q   <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          // Write wins when both requests arrive together.
          if (write_i) begin
            line_buf <= line_i;
            addr_q   <= address_i;
            count    <= 2'd0;
          end else if (read_i) begin
            addr_q <= address_i;
            count  <= 2'd0;
          end
        end
        READ: begin
          if (resp_i) begin
            line_o[s_burst*int'(count) +: s_burst] <= burst_i;
            count <= count + 2'd1;
          end
        end
        WRITE: begin
          if (resp_i) begin
            count <= count + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state logic; handshake outputs depend on state only.
  always_comb begin
    state_next = state;
    read_o     = 1'b0;
    write_o    = 1'b0;
    resp_o     = 1'b0;
    case (state)
      IDLE: begin
        if (write_i) begin
          state_next = WRITE;
        end else if (read_i) begin
          state_next = READ;
        end
      end
      READ: begin
        read_o = 1'b1;
        if (resp_i && (count == last_beat)) begin
          state_next = DONE;
        end
      end
      WRITE: begin
        write_o = 1'b1;
        if (resp_i && (count == last_beat)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        resp_o     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The outgoing beat tracks the count, so a stalled cycle keeps presenting
  // the same beat until memory accepts it.
  assign burst_o = line_buf[s_burst*int'(count) +: s_burst];

`ifdef CACHELINE_ADAPTOR_ADDR_ALIGN_EN
  assign address_o = {addr_q[31:5], 5'b0_0000};
`else
  assign address_o = addr_q;
`endif

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb_cacheline_adaptor
//   Directed self-checking bench for cacheline_adaptor. Inputs are changed
//   1 time unit after each rising edge and outputs are sampled at that same
//   point, so every value checked is the settled result of the last edge.

module tb_cacheline_adaptor;

  logic         clk;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int errors = 0;
  int checks = 0;

  cacheline_adaptor #(
    .s_line (256),
    .s_burst(64)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .line_i   (line_i),
    .line_o   (line_o),
    .address_i(address_i),
    .read_i   (read_i),
    .write_i  (write_i),
    .resp_o   (resp_o),
    .burst_i  (burst_i),
    .burst_o  (burst_o),
    .address_o(address_o),
    .read_o   (read_o),
    .write_o  (write_o),
    .resp_i   (resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive the request/beat inputs, then advance one clock edge.
  task automatic applyStimulus(input logic rd, input logic wr, input logic rsp,
                               input logic [63:0] beat);
    read_i  = rd;
    write_i = wr;
    resp_i  = rsp;
    burst_i = beat;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  localparam logic [63:0] W1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] W2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] W3 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] W4 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] W5 = 64'h5555_5555_5555_5555;
  localparam logic [63:0] W6 = 64'h6666_6666_6666_6666;
  localparam logic [63:0] W7 = 64'h7777_7777_7777_7777;
  localparam logic [63:0] W8 = 64'h8888_8888_8888_8888;
  localparam logic [63:0] BAD = 64'hDEAD_BEEF_DEAD_BEEF;

  initial begin
    logic         stall_pat [7];
    logic [63:0]  stall_dat [7];
    logic [255:0] stall_line;
    logic [31:0]  exp_align;

    rst       = 1'b1;
    line_i    = '0;
    address_i = '0;
    read_i    = 1'b0;
    write_i   = 1'b0;
    resp_i    = 1'b0;
    burst_i   = '0;

    // Reset state
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
    checkOutput("rst_read_o", 256'(read_o), 256'(1'b0));
    checkOutput("rst_write_o", 256'(write_o), 256'(1'b0));
    checkOutput("rst_resp_o", 256'(resp_o), 256'(1'b0));
    checkOutput("rst_line_o", line_o, 256'h0);
    checkOutput("rst_address_o", 256'(address_o), 256'h0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);

    // Basic read, four back-to-back beats
    $display("[TB] basic read");
    address_i = 32'h0000_1000;
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);
    checkOutput("rd_read_o", 256'(read_o), 256'(1'b1));
    checkOutput("rd_write_o", 256'(write_o), 256'(1'b0));
    checkOutput("rd_address_o", 256'(address_o), 256'(32'h0000_1000));
    applyStimulus(1'b1, 1'b0, 1'b1, 64'h0A);
    checkOutput("rd_resp_o_b0", 256'(resp_o), 256'(1'b0));
    applyStimulus(1'b1, 1'b0, 1'b1, 64'h0B);
    applyStimulus(1'b1, 1'b0, 1'b1, 64'h0C);
    checkOutput("rd_resp_o_b2", 256'(resp_o), 256'(1'b0));
    applyStimulus(1'b1, 1'b0, 1'b1, 64'h0D);
    checkOutput("rd_resp_o", 256'(resp_o), 256'(1'b1));
    checkOutput("rd_read_o_done", 256'(read_o), 256'(1'b0));
    checkOutput("rd_line_o", line_o, {64'h0D, 64'h0C, 64'h0B, 64'h0A});
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
    checkOutput("rd_resp_o_after", 256'(resp_o), 256'(1'b0));

    // Write burst; line_i changes after the request to prove it was latched
    $display("[TB] write burst");
    line_i    = {W4, W3, W2, W1};
    address_i = 32'h0000_1240;
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0);
    line_i    = '0;
    address_i = 32'hFFFF_FFFF;
    checkOutput("wr_write_o", 256'(write_o), 256'(1'b1));
    checkOutput("wr_read_o", 256'(read_o), 256'(1'b0));
    checkOutput("wr_beat0", 256'(burst_o), 256'(W1));
    applyStimulus(1'b0, 1'b1, 1'b1, 64'h0);
    checkOutput("wr_beat1", 256'(burst_o), 256'(W2));
    checkOutput("wr_address_o_b1", 256'(address_o), 256'(32'h0000_1240));
    applyStimulus(1'b0, 1'b1, 1'b1, 64'h0);
    checkOutput("wr_beat2", 256'(burst_o), 256'(W3));
    applyStimulus(1'b0, 1'b1, 1'b1, 64'h0);
    checkOutput("wr_beat3", 256'(burst_o), 256'(W4));
    checkOutput("wr_address_o_b3", 256'(address_o), 256'(32'h0000_1240));
    checkOutput("wr_resp_o_b3", 256'(resp_o), 256'(1'b0));
    applyStimulus(1'b0, 1'b1, 1'b1, 64'h0);
    checkOutput("wr_resp_o", 256'(resp_o), 256'(1'b1));
    checkOutput("wr_write_o_done", 256'(write_o), 256'(1'b0));
    checkOutput("wr_line_o_held", line_o, {64'h0D, 64'h0C, 64'h0B, 64'h0A});
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
    checkOutput("wr_resp_o_after", 256'(resp_o), 256'(1'b0));

    // Read with stalls: resp_i pattern 1,0,0,1,1,0,1
    $display("[TB] stalled read");
    stall_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    stall_dat = '{64'hE1, BAD, BAD, 64'hE2, 64'hE3, BAD, 64'hE4};
    stall_line = {64'hE4, 64'hE3, 64'hE2, 64'hE1};
    address_i = 32'h0000_2000;
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, 1'b0, stall_pat[i], stall_dat[i]);
      if (i < 6) begin
        checkOutput($sformatf("st_read_o_%0d", i), 256'(read_o), 256'(1'b1));
        checkOutput($sformatf("st_resp_o_%0d", i), 256'(resp_o), 256'(1'b0));
      end
    end
    checkOutput("st_resp_o", 256'(resp_o), 256'(1'b1));
    checkOutput("st_line_o", line_o, stall_line);
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);

    // Simultaneous read and write requests: write wins
    $display("[TB] read+write priority");
    line_i    = {W8, W7, W6, W5};
    address_i = 32'h0000_3000;
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
    checkOutput("pr_write_o", 256'(write_o), 256'(1'b1));
    checkOutput("pr_read_o", 256'(read_o), 256'(1'b0));
    checkOutput("pr_beat0", 256'(burst_o), 256'(W5));
    applyStimulus(1'b1, 1'b1, 1'b1, BAD);
    checkOutput("pr_read_o_b1", 256'(read_o), 256'(1'b0));
    checkOutput("pr_beat1", 256'(burst_o), 256'(W6));
    applyStimulus(1'b1, 1'b1, 1'b1, BAD);
    checkOutput("pr_read_o_b2", 256'(read_o), 256'(1'b0));
    applyStimulus(1'b1, 1'b1, 1'b1, BAD);
    checkOutput("pr_beat3", 256'(burst_o), 256'(W8));
    applyStimulus(1'b1, 1'b1, 1'b1, BAD);
    checkOutput("pr_resp_o", 256'(resp_o), 256'(1'b1));
    checkOutput("pr_read_o_done", 256'(read_o), 256'(1'b0));
    checkOutput("pr_line_o_held", line_o, stall_line);
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);

    // Reset in the middle of a read abandons it
    $display("[TB] reset mid-read");
    address_i = 32'h0000_4000;
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 64'hF1);
    applyStimulus(1'b1, 1'b0, 1'b1, 64'hF2);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);
    rst = 1'b0;
    checkOutput("mr_read_o", 256'(read_o), 256'(1'b0));
    checkOutput("mr_line_o", line_o, 256'h0);
    checkOutput("mr_address_o", 256'(address_o), 256'h0);
    checkOutput("mr_resp_o", 256'(resp_o), 256'(1'b0));
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, BAD);
      checkOutput($sformatf("mr_idle_resp_o_%0d", i), 256'(resp_o), 256'(1'b0));
      checkOutput($sformatf("mr_idle_read_o_%0d", i), 256'(read_o), 256'(1'b0));
    end
    checkOutput("mr_idle_line_o", line_o, 256'h0);
    address_i = 32'h0000_5000;
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);
    checkOutput("mr2_read_o", 256'(read_o), 256'(1'b1));
    applyStimulus(1'b1, 1'b0, 1'b1, 64'h11);
    applyStimulus(1'b1, 1'b0, 1'b1, 64'h22);
    applyStimulus(1'b1, 1'b0, 1'b1, 64'h33);
    applyStimulus(1'b1, 1'b0, 1'b1, 64'h44);
    checkOutput("mr2_resp_o", 256'(resp_o), 256'(1'b1));
    checkOutput("mr2_line_o", line_o, {64'h44, 64'h33, 64'h22, 64'h11});
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);

    // Address alignment option
    $display("[TB] address alignment");
`ifdef CACHELINE_ADAPTOR_ADDR_ALIGN_EN
    exp_align = 32'h0000_1240;
`else
    exp_align = 32'h0000_125C;
`endif
    address_i = 32'h0000_125C;
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);
    checkOutput("al_address_o", 256'(address_o), 256'(exp_align));
    applyStimulus(1'b1, 1'b0, 1'b1, 64'h1);
    applyStimulus(1'b1, 1'b0, 1'b1, 64'h2);
    applyStimulus(1'b1, 1'b0, 1'b1, 64'h3);
    checkOutput("al_address_o_b2", 256'(address_o), 256'(exp_align));
    applyStimulus(1'b1, 1'b0, 1'b1, 64'h4);
    checkOutput("al_resp_o", 256'(resp_o), 256'(1'b1));
    checkOutput("al_line_o", line_o, {64'h4, 64'h3, 64'h2, 64'h1});
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
    checkOutput("al_resp_o_after", 256'(resp_o), 256'(1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
